// File: rtl/block_accum_pkg.sv
// Shared constants and helpers for the multi-channel block accumulator.
package block_accum_pkg;

  localparam int ACC_WRAP = 0;
  localparam int ACC_SAT  = 1;

  // Channel index width; at least one bit even for a single channel.
  function automatic int ch_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One accumulator channel: running sum, sample count and sticky overflow.
// done/sum/ovf describe the result produced by the current hit when it closes a block.
module accum_lane
  import block_accum_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 4,
  parameter int SATURATE  = ACC_WRAP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              clear,
  input  logic [DATA_W-1:0] data,
  output logic              done,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  logic [ACC_W-1:0] acc_q, acc_d, new_acc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   t;
  logic             carry, nov, last;

  always_comb begin
    t       = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, data};
    carry   = t[ACC_W];
    new_acc = (carry && (SATURATE == ACC_SAT)) ? '1 : t[ACC_W-1:0];
    nov     = ovf_q | carry;
    last    = (cnt_q == LAST);

    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear || (hit && last)) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (hit) begin
      acc_d = new_acc;
      cnt_d = cnt_q + CNT_W'(1);
      ovf_d = nov;
    end
  end

  // Clear discards a coincident sample, so it also suppresses the result.
  assign done = hit && last && !clear;
  assign sum  = new_acc;
  assign ovf  = nov;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/block_accum_mc.sv
// Multi-channel block accumulator: channel decode, valid/ready handshake
// and a single registered output slot shared by all channels.
module block_accum_mc
  import block_accum_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int ACC_W     = 8,
  parameter int NUM_CH    = 4,
  parameter int BLOCK_LEN = 4,
  parameter int SATURATE  = ACC_WRAP,
  localparam int CH_W     = ch_w(NUM_CH)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              InValid,
  output logic              InReady,
  input  logic [CH_W-1:0]   InChan,
  input  logic [DATA_W-1:0] Data,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [CH_W-1:0]   OutChan,
  output logic [ACC_W-1:0]  OutSum,
  output logic              OutOvf
);

  logic              acc_in, xfer;
  logic [NUM_CH-1:0] hit, done, ovf_lane;
  logic [ACC_W-1:0]  sum_lane [NUM_CH];

  logic              out_valid_q, out_valid_d;
  logic              out_ovf_q, out_ovf_d;
  logic [CH_W-1:0]   out_chan_q, out_chan_d;
  logic [ACC_W-1:0]  out_sum_q, out_sum_d;

  assign InReady = !out_valid_q || OutReady;
  assign acc_in  = InValid && InReady;
  assign xfer    = out_valid_q && OutReady;

  // Out-of-range channel indices match no lane: accepted, then dropped.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    assign hit[gi] = acc_in && (InChan == CH_W'(gi));

    accum_lane #(
      .DATA_W    (DATA_W),
      .ACC_W     (ACC_W),
      .BLOCK_LEN (BLOCK_LEN),
      .SATURATE  (SATURATE)
    ) u_lane (
      .clk   (Clock),
      .rst_n (Reset),
      .hit   (hit[gi]),
      .clear (Clear),
      .data  (Data),
      .done  (done[gi]),
      .sum   (sum_lane[gi]),
      .ovf   (ovf_lane[gi])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    if (xfer) out_valid_d = 1'b0;
    // At most one lane completes per cycle; a new result overrides the transfer.
    for (int i = 0; i < NUM_CH; i++) begin
      if (done[i]) begin
        out_valid_d = 1'b1;
        out_chan_d  = CH_W'(i);
        out_sum_d   = sum_lane[i];
        out_ovf_d   = ovf_lane[i];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign OutValid = out_valid_q;
  assign OutChan  = out_chan_q;
  assign OutSum   = out_sum_q;
  assign OutOvf   = out_ovf_q;

endmodule

// File: tb/tb_block_accum_mc.sv
// Bench for block_accum_mc: directed scenarios plus random traffic against a
// per-channel running-total reference model, across several parameterisations.
module tb_block_accum_mc;
  import block_accum_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Clear = 1'b0;
  logic       InValid = 1'b0;
  logic       OutReady = 1'b1;
  logic [1:0] InChan = '0;
  logic [3:0] Data = '0;

  logic       rdy0, rdy1, rdy2, vld0, vld1, vld2, ovf0, ovf1, ovf2;
  logic [1:0] chan0, chan1, chan2;
  logic [7:0] sum0;
  logic [4:0] sum1, sum2;

  // Second stimulus group: NUM_CH=3 (out-of-range index 3), BLOCK_LEN 2 and 1.
  logic       c_valid = 1'b0;
  logic [1:0] c_chan = '0;
  logic [3:0] c_data = '0;
  logic       b_rdy, b_vld, b_ovf, e_rdy, e_vld, e_ovf;
  logic [1:0] b_chan, e_chan;
  logic [7:0] b_sum, e_sum;

  int n_vec = 0;
  int n_fail = 0;

  // Reference model for the shared-input group: unbounded per-channel totals.
  int tot[4];
  int cnt[4];
  bit m_valid;
  int m_chan, m_tot;
  int tot3[3];
  int cnt3[3];

  always #5 Clock = ~Clock;

  block_accum_mc #(.DATA_W(4), .ACC_W(8), .NUM_CH(4), .BLOCK_LEN(4), .SATURATE(ACC_WRAP)) dut0 (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InReady(rdy0),
    .InChan(InChan), .Data(Data), .OutValid(vld0), .OutReady(OutReady),
    .OutChan(chan0), .OutSum(sum0), .OutOvf(ovf0));

  block_accum_mc #(.DATA_W(4), .ACC_W(5), .NUM_CH(4), .BLOCK_LEN(4), .SATURATE(ACC_SAT)) dut1 (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InReady(rdy1),
    .InChan(InChan), .Data(Data), .OutValid(vld1), .OutReady(OutReady),
    .OutChan(chan1), .OutSum(sum1), .OutOvf(ovf1));

  block_accum_mc #(.DATA_W(4), .ACC_W(5), .NUM_CH(4), .BLOCK_LEN(4), .SATURATE(ACC_WRAP)) dut2 (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .InValid(InValid), .InReady(rdy2),
    .InChan(InChan), .Data(Data), .OutValid(vld2), .OutReady(OutReady),
    .OutChan(chan2), .OutSum(sum2), .OutOvf(ovf2));

  block_accum_mc #(.DATA_W(4), .ACC_W(8), .NUM_CH(3), .BLOCK_LEN(2), .SATURATE(ACC_WRAP)) dut3 (
    .Clock(Clock), .Reset(Reset), .Clear(1'b0), .InValid(c_valid), .InReady(b_rdy),
    .InChan(c_chan), .Data(c_data), .OutValid(b_vld), .OutReady(1'b1),
    .OutChan(b_chan), .OutSum(b_sum), .OutOvf(b_ovf));

  block_accum_mc #(.DATA_W(4), .ACC_W(8), .NUM_CH(3), .BLOCK_LEN(1), .SATURATE(ACC_WRAP)) dut4 (
    .Clock(Clock), .Reset(Reset), .Clear(1'b0), .InValid(c_valid), .InReady(e_rdy),
    .InChan(c_chan), .Data(c_data), .OutValid(e_vld), .OutReady(1'b1),
    .OutChan(e_chan), .OutSum(e_sum), .OutOvf(e_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_sum(input int t, input int w, input bit sat);
    int mx;
    mx = (1 << w) - 1;
    if (t <= mx) return t;
    return sat ? mx : (t % (1 << w));
  endfunction

  function automatic int exp_ovf(input int t, input int w);
    return (t > (1 << w) - 1) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin tot[c] = 0; cnt[c] = 0; end
    for (int c = 0; c < 3; c++) begin tot3[c] = 0; cnt3[c] = 0; end
    m_valid = 0; m_chan = 0; m_tot = 0;
  endtask

  // One clock of the shared-input group: check readiness, clock, update model, check slot.
  task automatic step();
    bit rdy, accd, xfer;
    #1;
    rdy = !m_valid || OutReady;
    chk("in_ready0", rdy0, rdy);
    chk("in_ready1", rdy1, rdy);
    chk("in_ready2", rdy2, rdy);
    accd = InValid && rdy;
    xfer = m_valid && OutReady;
    @(posedge Clock);
    #1;
    if (xfer) m_valid = 0;
    if (Clear) begin
      for (int c = 0; c < 4; c++) begin tot[c] = 0; cnt[c] = 0; end
    end else if (accd) begin
      tot[InChan] += int'(Data);
      cnt[InChan]++;
      if (cnt[InChan] == 4) begin
        m_valid = 1; m_chan = int'(InChan); m_tot = tot[InChan];
        tot[InChan] = 0; cnt[InChan] = 0;
      end
    end
    chk("out_valid0", vld0, m_valid);
    chk("out_valid1", vld1, m_valid);
    chk("out_valid2", vld2, m_valid);
    if (m_valid) begin
      chk("out_chan0", chan0, m_chan);
      chk("out_chan1", chan1, m_chan);
      chk("out_sum0", sum0, exp_sum(m_tot, 8, 0));
      chk("out_ovf0", ovf0, exp_ovf(m_tot, 8));
      chk("out_sum_sat", sum1, exp_sum(m_tot, 5, 1));
      chk("out_ovf_sat", ovf1, exp_ovf(m_tot, 5));
      chk("out_sum_wrap", sum2, exp_sum(m_tot, 5, 0));
      chk("out_ovf_wrap", ovf2, exp_ovf(m_tot, 5));
    end
  endtask

  task automatic feed(input int ch, input int d);
    InValid = 1'b1;
    InChan = 2'(ch);
    Data = 4'(d);
    step();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, {vld0, vld1, vld2, b_vld, e_vld}, 0);
    chk({tag, "_sum"}, {sum0, sum1, sum2}, 0);
    chk({tag, "_chan"}, {chan0, chan1, chan2}, 0);
    chk({tag, "_ovf"}, {ovf0, ovf1, ovf2}, 0);
  endtask

  initial begin
    int tb_chan[3];
    int tb_data[3];
    bit bv, ev;
    int bs;
    tb_chan = '{0, 3, 0};
    tb_data = '{5, 9, 6};
    model_reset();

    // Power-up reset
    #1 Reset = 1'b0;
    #2 check_zero("por");
    repeat (2) @(posedge Clock);
    #2 Reset = 1'b1;
    step();

    // ch0 1,2,3,4 back-to-back
    for (int i = 1; i <= 4; i++) feed(0, i);
    chk("t2_sum", sum0, 10);
    chk("t2_chan", chan0, 0);
    chk("t2_ovf", ovf0, 0);

    // Interleaved ch1 (15s) and ch2 (1s)
    for (int i = 0; i < 3; i++) begin feed(1, 15); feed(2, 1); end
    feed(1, 15);
    chk("t3_sum_ch1", sum0, 60);
    chk("t3_chan_ch1", chan0, 1);
    feed(2, 1);
    chk("t3_sum_ch2", sum0, 4);
    chk("t3_chan_ch2", chan0, 2);

    // Overflow in the 5-bit variants, then a clean block
    for (int i = 0; i < 4; i++) feed(0, 15);
    chk("t4_sat_sum", sum1, 31);
    chk("t4_sat_ovf", ovf1, 1);
    chk("t4_wrap_sum", sum2, 28);
    chk("t4_wrap_ovf", ovf2, 1);
    for (int i = 0; i < 4; i++) feed(0, 1);
    chk("t4_sat_sum2", sum1, 4);
    chk("t4_sat_ovf2", ovf1, 0);
    chk("t4_wrap_sum2", sum2, 4);

    // Back-pressure, then transfer and new load on the same edge
    for (int i = 0; i < 3; i++) begin feed(0, 2); feed(1, 3); end
    feed(0, 2);
    OutReady = 1'b0;
    for (int i = 0; i < 3; i++) feed(1, 3);
    chk("t5_hold_ready", rdy0, 0);
    chk("t5_hold_sum", sum0, 8);
    OutReady = 1'b1;
    feed(1, 3);
    chk("t5_reload_valid", vld0, 1);
    chk("t5_reload_chan", chan0, 1);
    chk("t5_reload_sum", sum0, 12);

    // Clear wins over a coincident sample
    feed(3, 1); feed(3, 1);
    Clear = 1'b1;
    feed(3, 1);
    Clear = 1'b0;
    for (int i = 0; i < 4; i++) feed(3, 1);
    chk("t6_clear_sum", sum0, 4);
    chk("t6_clear_chan", chan0, 3);

    // Reset mid-stream with a pending result and partial sums
    OutReady = 1'b0;
    for (int i = 0; i < 4; i++) feed(2, 7);
    feed(1, 5);
    #2 Reset = 1'b0;
    #1 check_zero("mid_rst");
    model_reset();
    @(posedge Clock);
    #2 Reset = 1'b1;
    InValid = 1'b0;
    OutReady = 1'b1;
    step();
    chk("post_rst_ready", rdy0, 1);
    for (int i = 0; i < 4; i++) feed(1, 1);
    chk("post_rst_sum", sum0, 4);

    // Random traffic on the shared-input group
    for (int k = 0; k < 400; k++) begin
      InValid  = ($urandom_range(0, 3) != 0);
      InChan   = 2'($urandom_range(0, 3));
      Data     = 4'($urandom_range(0, 15));
      OutReady = ($urandom_range(0, 2) != 0);
      Clear    = ($urandom_range(0, 29) == 0);
      step();
    end
    InValid = 1'b0;
    Clear = 1'b0;

    // NUM_CH=3: index 3 is dropped; BLOCK_LEN=2 and BLOCK_LEN=1 variants
    for (int k = 0; k < 60; k++) begin
      if (k < 3) begin
        c_valid = 1'b1;
        c_chan  = 2'(tb_chan[k]);
        c_data  = 4'(tb_data[k]);
      end else begin
        c_valid = ($urandom_range(0, 3) != 0);
        c_chan  = 2'($urandom_range(0, 3));
        c_data  = 4'($urandom_range(0, 15));
      end
      #1;
      chk("b_in_ready", b_rdy, 1);
      chk("e_in_ready", e_rdy, 1);
      @(posedge Clock);
      #1;
      bv = 0; ev = 0; bs = 0;
      if (c_valid && c_chan < 2'd3) begin
        ev = 1;
        tot3[c_chan] += int'(c_data);
        cnt3[c_chan]++;
        if (cnt3[c_chan] == 2) begin
          bv = 1; bs = tot3[c_chan];
          tot3[c_chan] = 0; cnt3[c_chan] = 0;
        end
      end
      chk("b_valid", b_vld, bv);
      chk("e_valid", e_vld, ev);
      if (bv) begin
        chk("b_sum", b_sum, bs);
        chk("b_chan", b_chan, c_chan);
        chk("b_ovf", b_ovf, 0);
      end
      if (ev) begin
        chk("e_sum", e_sum, c_data);
        chk("e_chan", e_chan, c_chan);
        chk("e_ovf", e_ovf, 0);
      end
      if (k == 2) chk("drop_ch3_sum", b_sum, 11);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
